// File: rtl/rf_wport_arbiter.sv
// Two-pipe writeback arbiter for the single register-file write port.
// Round-robin on distinct-address contention, younger-wins on same-address
// collisions, register-0 writes discarded, one registered write per cycle.
module rf_wport_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          stall,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          rr_ptr,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [CW-1:0] DROP_MAX = '1;

  logic          live0;
  logic          live1;
  logic          same_addr;
  logic          wr_go;
  logic [AW-1:0] wr_addr_nxt;
  logic [DW-1:0] wr_data_nxt;
  logic          rr_flip;
  logic          drop_inc;

  assign live0     = req0_valid && (req0_addr != '0);
  assign live1     = req1_valid && (req1_addr != '0);
  assign same_addr = (req0_addr == req1_addr);

  // Accept/grant decision; ready never looks at the output register.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    wr_go       = 1'b0;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    rr_flip     = 1'b0;
    drop_inc    = 1'b0;
    if (!arst && !stall) begin
      // register-0 requests are swallowed without using the port
      req0_ready = req0_valid && !live0;
      req1_ready = req1_valid && !live1;
      if (live0 && live1 && same_addr) begin
        req0_ready  = 1'b1;
        req1_ready  = 1'b1;
        wr_go       = 1'b1;
        wr_addr_nxt = req1_addr;
        wr_data_nxt = req1_data;
        drop_inc    = 1'b1;
      end else if (live0 && live1) begin
        wr_go   = 1'b1;
        rr_flip = 1'b1;
        if (rr_ptr) begin
          req1_ready  = 1'b1;
          wr_addr_nxt = req1_addr;
          wr_data_nxt = req1_data;
        end else begin
          req0_ready  = 1'b1;
          wr_addr_nxt = req0_addr;
          wr_data_nxt = req0_data;
        end
      end else if (live0) begin
        req0_ready  = 1'b1;
        wr_go       = 1'b1;
        wr_addr_nxt = req0_addr;
        wr_data_nxt = req0_data;
      end else if (live1) begin
        req1_ready  = 1'b1;
        wr_go       = 1'b1;
        wr_addr_nxt = req1_addr;
        wr_data_nxt = req1_data;
      end
    end
  end

  // Output write register, round-robin pointer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rr_ptr   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr <= wr_addr_nxt;
        wr_data <= wr_data_nxt;
      end
      if (rr_flip) begin
        rr_ptr <= ~rr_ptr;
      end
      if (drop_inc && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed plan steps, a randomized
// phase with rule-based reference model, saturation and mid-operation reset.
module tb_rf_wport_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst;
  logic          stall;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rr_ptr;
  logic [CW-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int            m_rr;
  int            m_drop;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit            e_r0, e_r1;
  bit            acc0, acc1;

  rf_wport_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .arst(arst), .stall(stall),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which requests the rules accept this cycle.
  task automatic model_ready();
    int nlive;
    bit l0, l1;
    l0 = v0 && (a0 != 0);
    l1 = v1 && (a1 != 0);
    nlive = int'(l0) + int'(l1);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!arst && !stall) begin
      if (v0 && a0 == 0) e_r0 = 1'b1;
      if (v1 && a1 == 0) e_r1 = 1'b1;
      case (nlive)
        1: if (l0) e_r0 = 1'b1; else e_r1 = 1'b1;
        2: if (a0 == a1) begin e_r0 = 1'b1; e_r1 = 1'b1; end
           else if (m_rr == 0) e_r0 = 1'b1;
           else e_r1 = 1'b1;
        default: ;
      endcase
    end
  endtask

  // State after the clock edge according to the rules.
  task automatic model_edge();
    bit l0, l1;
    l0 = v0 && (a0 != 0);
    l1 = v1 && (a1 != 0);
    if (arst) begin
      m_wen = 0; m_waddr = '0; m_wdata = '0; m_rr = 0; m_drop = 0;
    end else if (stall || (!l0 && !l1)) begin
      m_wen = 0;
    end else if (l0 && l1 && a0 == a1) begin
      m_wen = 1; m_waddr = a1; m_wdata = d1;
      if (m_drop < DROP_MAX) m_drop = m_drop + 1;
    end else if (l0 && l1) begin
      m_wen = 1;
      if (m_rr == 0) begin m_waddr = a0; m_wdata = d0; end
      else begin m_waddr = a1; m_wdata = d1; end
      m_rr = 1 - m_rr;
    end else if (l0) begin
      m_wen = 1; m_waddr = a0; m_wdata = d0;
    end else begin
      m_wen = 1; m_waddr = a1; m_wdata = d1;
    end
  endtask

  // One clock: check readies mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    model_ready();
    acc0 = v0 && e_r0;
    acc1 = v1 && e_r1;
    #1;
    chk("ready0", 64'(rdy0), 64'(e_r0));
    chk("ready1", 64'(rdy1), 64'(e_r1));
    @(posedge clk);
    model_edge();
    #1;
    chk("wr_en", 64'(wr_en), 64'(m_wen));
    chk("wr_addr", 64'(wr_addr), 64'(m_waddr));
    chk("wr_data", 64'(wr_data), 64'(m_wdata));
    chk("rr_ptr", 64'(rr_ptr), 64'(m_rr));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  initial begin
    m_rr = 0; m_drop = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
    arst = 1'b1; stall = 1'b0;
    v0 = 1'b1; a0 = AW'(1); d0 = 32'h1;
    v1 = 1'b1; a1 = AW'(2); d1 = 32'h2;
    @(posedge clk); #1;

    // reset with both pipes valid
    cycle();
    cycle();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rr", 64'(rr_ptr), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);

    // single request
    arst = 1'b0;
    v0 = 1'b1; a0 = AW'(5); d0 = 32'hDEADBEEF;
    v1 = 1'b0;
    cycle();
    chk("single_en", 64'(wr_en), 64'd1);
    chk("single_addr", 64'(wr_addr), 64'd5);
    chk("single_data", 64'(wr_data), 64'hDEADBEEF);
    chk("single_rr", 64'(rr_ptr), 64'd0);

    // distinct-address contention: grants 0,1,0,1
    v0 = 1'b1; a0 = AW'(3); d0 = 32'h100;
    v1 = 1'b1; a1 = AW'(7); d1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("cont_addr", 64'(wr_addr), (i % 2 == 0) ? 64'd3 : 64'd7);
      if (acc0) d0 = d0 + 32'h1;
      if (acc1) d1 = d1 + 32'h1;
    end

    // same-address collision: younger data wins
    a0 = AW'(9); d0 = 32'h11;
    a1 = AW'(9); d1 = 32'h22;
    cycle();
    chk("coll_addr", 64'(wr_addr), 64'd9);
    chk("coll_data", 64'(wr_data), 64'h22);
    chk("coll_drop", 64'(drop_cnt), 64'd1);
    chk("coll_rr", 64'(rr_ptr), 64'd0);

    // zero register alongside a live write
    a0 = AW'(0); d0 = 32'h33;
    a1 = AW'(4); d1 = 32'h44;
    cycle();
    chk("zero_addr", 64'(wr_addr), 64'd4);
    chk("zero_data", 64'(wr_data), 64'h44);

    // stall with both live, then resume from held pointer
    stall = 1'b1;
    a0 = AW'(3); d0 = 32'h55;
    a1 = AW'(7); d1 = 32'h66;
    cycle();
    cycle();
    chk("stall_en", 64'(wr_en), 64'd0);
    stall = 1'b0;
    cycle();
    chk("resume_addr", 64'(wr_addr), 64'd3);
    chk("resume_rr", 64'(rr_ptr), 64'd1);

    // randomized traffic with held-until-accepted requesters
    for (int n = 0; n < 600; n++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 9) < 8);
        a0 = AW'($urandom_range(0, 3));
        d0 = $urandom;
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 9) < 8);
        a1 = AW'($urandom_range(0, 3));
        d1 = $urandom;
      end
      stall = ($urandom_range(0, 9) == 0);
      arst  = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // drop counter saturation
    arst = 1'b0; stall = 1'b0;
    v0 = 1'b1; a0 = AW'(12); d0 = 32'hA;
    v1 = 1'b1; a1 = AW'(12); d1 = 32'hB;
    for (int n = 0; n < (1 << CW) + 3; n++) begin
      cycle();
    end
    chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
    cycle();
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);

    // reset the cycle after an acceptance
    v1 = 1'b0; a0 = AW'(6); d0 = 32'h77;
    cycle();
    chk("pre_rst_en", 64'(wr_en), 64'd1);
    arst = 1'b1;
    cycle();
    chk("midrst_en", 64'(wr_en), 64'd0);
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
    arst = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
Arbitrates two superscalar pipe writeback streams onto the single register-file write port. The register file is built from the library flip-flop cells. The block applies a round-robin grant, resolves same-register write collisions in program order, discards writes to register 0 and registers the winning write for one-cycle delivery. Pipe 0 is the older instruction and pipe 1 the younger within an issue pair.

Parameters:
DW, 32, data width of a register write
AW, 5, register address width
CW, 16, width of the dropped-write statistics counter

Ports:
clk  in  1  clock, rising edge
arst  in  1  reset; arst, synchronous, active-high
stall  in  1  freeze: no acceptances, no new writes
req0_valid  in  1  pipe 0 (older) write request
req0_addr  in  AW  pipe 0 destination register
req0_data  in  DW  pipe 0 write data
req0_ready  out  1  pipe 0 request accepted this cycle (combinational)
req1_valid  in  1  pipe 1 (younger) write request
req1_addr  in  AW  pipe 1 destination register
req1_data  in  DW  pipe 1 write data
req1_ready  out  1  pipe 1 request accepted this cycle (combinational)
wr_en  out  1  register-file write enable (registered)
wr_addr  out  AW  register-file write address (registered)
wr_data  out  DW  register-file write data (registered)
rr_ptr  out  1  current round-robin priority holder (0 or 1)
drop_cnt  out  CW  saturating count of discarded older writes

Behaviour:
- Reset: when arst=1 at a rising edge, next state is wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, drop_cnt=0. arst overrides stall and all requests. req*_ready are 0 while arst=1.
- Handshake: request i is accepted in a cycle where reqi_valid=1 and reqi_ready=1. Once accepted, the request is done; the requester advances. An unaccepted request must hold valid, addr and data stable.
- readyi depends only on the current valid, addr, stall, arst and rr_ptr; it never depends on wr_en.
- stall=1: both ready=0. wr_en=0 on the next edge. rr_ptr and drop_cnt hold.
- Zero-register requests (valid with addr==0): always ready, never written, never count as a port use.
- "Live" request: valid=1 and addr!=0.
- Grant rules, evaluated when stall=0:
  - No live request: wr_en<=0; rr_ptr holds.
  - One live request: accept it; wr_en<=1 with its addr and data; rr_ptr holds.
  - Two live requests, different addresses: accept only pipe rr_ptr and write it; the other pipe's ready=0. rr_ptr<=~rr_ptr.
  - Two live requests, same address: accept both in the same cycle. Write req1 data only (younger wins). drop_cnt increments, saturating at all-ones. rr_ptr holds.
- Latency: an accepted write appears on wr_en/wr_addr/wr_data exactly 1 cycle after acceptance. There is at most 1 write per cycle. Back-to-back writes are sustained at 1 per cycle.
- wr_addr/wr_data hold their previous values when wr_en<=0 (no gratuitous toggling). wr_addr is never 0 while wr_en=1.
- Reset mid-operation: an accepted write still in the output register is discarded. Requests present during reset are not accepted and must be re-presented afterwards.
- Fairness: under continuous contention on distinct addresses, grants alternate strictly 0,1,0,1… starting from the rr_ptr value. Neither pipe waits more than 1 cycle.
- drop_cnt saturates at 2^CW-1 and never wraps.

Test Plan:
- Reset: apply arst for 2 cycles with both pipes valid → ready0=ready1=0, wr_en=0, rr_ptr=0, drop_cnt=0.
- Single request: req0 addr=5, data=0xDEADBEEF, req1 idle → ready0=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; rr_ptr stays 0.
- Contention: both valid every cycle for 4 cycles (req0 addr=3, req1 addr=7, each advancing data) → grants 0,1,0,1. Writes appear 3,7,3,7 one cycle later. rr_ptr toggles each cycle.
- Same-address collision: req0 addr=9 data=0x11, req1 addr=9 data=0x22 → both ready=1. Next cycle a single write addr=9 data=0x22. drop_cnt=1, rr_ptr unchanged.
- Zero register and stall: req0 addr=0 with req1 addr=4 → both accepted, one write to 4. Then stall=1 with both live → ready=0, wr_en=0, rr_ptr held. Release stall → arbitration resumes from the held rr_ptr.
- Saturation and mid-op reset: force 2^CW+3 collisions → drop_cnt=0xFFFF. Assert arst the cycle after an acceptance → wr_en=0 next cycle, drop_cnt=0.
